muldiv_unit: RTL and testbench

- EX-stage HI/LO unit directly downstream of instruction decode.
- Consumes the decoded R-format instruction plus Rdata1 (rs) and Rdata2 (rt).
- Executes MULT, MULTU, DIV and DIVU iteratively, handles MTHI, MTLO, MFHI and MFLO, and owns the HI/LO architectural registers.
- Raises Stall so upstream stages hold while an operation is in flight.

---
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: EX-stage HI/LO unit. Runs MULT/MULTU/DIV/DIVU as WIDTH-step
// iterative operations, performs MTHI/MTLO/MFHI/MFLO, and owns Hi/Lo.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Valid,
    input  logic [31:0]      Ins,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    output logic             Busy,
    output logic             Stall,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] MfData
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               state, next_state;
    logic [CNT_W-1:0]     counter;
    logic [2*WIDTH-1:0]   acc;        // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]     opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     raw_a;      // unmodified dividend for divide-by-zero
    logic                 op_div;
    logic                 neg_q;
    logic                 neg_r;
    logic                 div_zero;

    logic [5:0]           funct;
    logic                 r_form;
    logic                 hilo_op;
    logic                 accept;
    logic                 is_mul;
    logic                 is_div;
    logic                 is_signed;
    logic                 sign1;
    logic                 sign2;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic                 ins_unused;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;
    logic                 last_iter;

    assign funct      = Ins[5:0];
    assign r_form     = (Ins[31:26] == 6'b000000);
    assign ins_unused = ^Ins[25:6];

    // Instruction decode, operand magnitudes and handshake signals.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        hilo_op   = 1'b0;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        if (r_form) begin
            hilo_op   = (funct == F_MFHI) || (funct == F_MTHI) || (funct == F_MFLO) ||
                        (funct == F_MTLO) || (funct == F_MULT) || (funct == F_MULTU) ||
                        (funct == F_DIV)  || (funct == F_DIVU);
            is_mul    = (funct == F_MULT) || (funct == F_MULTU);
            is_div    = (funct == F_DIV)  || (funct == F_DIVU);
            is_signed = (funct == F_MULT) || (funct == F_DIV);
        end
        sign1  = is_signed & Rdata1[WIDTH-1];
        sign2  = is_signed & Rdata2[WIDTH-1];
        mag1   = sign1 ? (WIDTH'(0) - Rdata1) : Rdata1;
        mag2   = sign2 ? (WIDTH'(0) - Rdata2) : Rdata2;
        accept = Valid & ~Busy & hilo_op;
        Stall  = Valid & Busy & hilo_op;
    end

    // One shift-add / shift-subtract step plus the final sign correction.
    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : WIDTH'(0))};
        mul_next   = {mul_sum, acc[WIDTH-1:1]};
        div_shift  = acc[2*WIDTH-1:WIDTH-1];
        div_diff   = div_shift - {1'b0, opnd};
        div_next   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
        prod_fixed = neg_q ? ((2*WIDTH)'(0) - acc) : acc;
        fix_hi     = prod_fixed[2*WIDTH-1:WIDTH];
        fix_lo     = prod_fixed[WIDTH-1:0];
        if (op_div) begin
            if (div_zero) begin
                fix_hi = raw_a;
                fix_lo = '1;
            end else begin
                fix_hi = neg_r ? (WIDTH'(0) - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
                fix_lo = neg_q ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
            end
        end
        last_iter = (counter == CNT_W'(WIDTH - 1));
    end

    // MFHI/MFLO read port.
    always_comb begin
        MfData = '0;
        if (Valid && r_form && funct == F_MFHI) MfData = Hi;
        if (Valid && r_form && funct == F_MFLO) MfData = Lo;
    end

    // Next-state logic for the operation sequencer.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept && is_mul) next_state = S_MUL;
                if (accept && is_div) next_state = S_DIV;
            end
            S_MUL, S_DIV: if (last_iter) next_state = S_FIX;
            S_FIX:        next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // State register and registered Busy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= S_IDLE;
            Busy  <= 1'b0;
        end else begin
            state <= next_state;
            Busy  <= (next_state != S_IDLE);
        end
    end

    // Datapath: operand capture, iteration, result writeback and moves.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: the accumulators are plain registers, not a memory, so they are cleared here too.
            Hi       <= '0;
            Lo       <= '0;
            counter  <= '0;
            acc      <= '0;
            opnd     <= '0;
            raw_a    <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (funct == F_MTHI) Hi <= Rdata1;
                        if (funct == F_MTLO) Lo <= Rdata1;
                        if (is_mul || is_div) begin
                            counter  <= '0;
                            op_div   <= is_div;
                            neg_q    <= sign1 ^ sign2;
                            neg_r    <= is_div & sign1;
                            div_zero <= is_div & (Rdata2 == '0);
                            raw_a    <= Rdata1;
                            acc      <= is_div ? {WIDTH'(0), mag1} : {WIDTH'(0), mag2};
                            opnd     <= is_div ? mag2 : mag1;
                        end
                    end
                end
                S_MUL: begin
                    acc     <= mul_next;
                    counter <= counter + 1'b1;
                end
                S_DIV: begin
                    acc     <= div_next;
                    counter <= counter + 1'b1;
                end
                S_FIX: begin
                    Hi      <= fix_hi;
                    Lo      <= fix_lo;
                    counter <= '0;
                end
                default: counter <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: latency, signed/unsigned results,
// divide corner cases, stall/move handling and asynchronous reset.
module tb_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Valid = 1'b0;
    logic [31:0] Ins = '0;
    logic [31:0] Rdata1 = '0;
    logic [31:0] Rdata2 = '0;
    logic        Busy;
    logic        Stall;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [31:0] MfData;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK(CLK), .RST(RST), .Valid(Valid), .Ins(Ins),
        .Rdata1(Rdata1), .Rdata2(Rdata2), .Busy(Busy), .Stall(Stall),
        .Hi(Hi), .Lo(Lo), .MfData(MfData)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] r_ins(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    // Issue one instruction and count the negedges on which Busy is seen high.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        @(negedge CLK);
        Valid = 1'b1; Ins = r_ins(f); Rdata1 = a; Rdata2 = b;
        @(negedge CLK);
        Valid = 1'b0; Rdata1 = 32'hDEADBEEF; Rdata2 = 32'h5A5A5A5A;
        cyc = 0;
        while (Busy && cyc < 200) begin
            cyc++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset;
        RST = 1'b0;
        #2;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b want 0", Busy); end
        checks++; if (Hi !== 32'd0) begin failures++; $display("FAIL reset_hi got %h want 0", Hi); end
        checks++; if (Lo !== 32'd0) begin failures++; $display("FAIL reset_lo got %h want 0", Lo); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %0b want 0", Stall); end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_ignored;
        @(negedge CLK);
        Valid = 1'b1; Ins = r_ins(6'h20); Rdata1 = 32'h55; Rdata2 = 32'h66;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL ignored_stall got %0b want 0", Stall); end
        checks++; if (MfData !== 32'd0) begin failures++; $display("FAIL ignored_mfdata got %h want 0", MfData); end
        @(negedge CLK);
        Ins = {6'h08, 20'd0, F_MULT};
        @(negedge CLK);
        Ins = {6'h0F, 20'd0, F_MTHI};
        @(negedge CLK);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL ignored_busy got %0b want 0", Busy); end
        checks++; if (Hi !== 32'd0) begin failures++; $display("FAIL ignored_hi got %h want 0", Hi); end
        Valid = 1'b0;
    endtask

    task automatic test_multu;
        int cyc;
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL multu_busy_cycles got %0d want 33", cyc); end
        checks++; if (Hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got %h want fffffffe", Hi); end
        checks++; if (Lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got %h want 00000001", Lo); end
    endtask

    task automatic test_mult;
        int cyc;
        run_op(F_MULT, 32'hFFFFFFFD, 32'd7, cyc);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL mult_busy_cycles got %0d want 33", cyc); end
        checks++; if (Hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_neg_hi got %h want ffffffff", Hi); end
        checks++; if (Lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_neg_lo got %h want ffffffeb", Lo); end
        run_op(F_MULT, 32'h80000000, 32'h80000000, cyc);
        checks++; if (Hi !== 32'h40000000) begin failures++; $display("FAIL mult_min_hi got %h want 40000000", Hi); end
        checks++; if (Lo !== 32'h00000000) begin failures++; $display("FAIL mult_min_lo got %h want 0", Lo); end
    endtask

    task automatic test_div;
        int cyc;
        run_op(F_DIV, 32'hFFFFFFF9, 32'd2, cyc);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL div_busy_cycles got %0d want 33", cyc); end
        checks++; if (Lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_lo got %h want fffffffd", Lo); end
        checks++; if (Hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_hi got %h want ffffffff", Hi); end
        run_op(F_DIVU, 32'd100, 32'd7, cyc);
        checks++; if (Lo !== 32'd14) begin failures++; $display("FAIL divu_lo got %0d want 14", Lo); end
        checks++; if (Hi !== 32'd2) begin failures++; $display("FAIL divu_hi got %0d want 2", Hi); end
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
        checks++; if (Lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got %h want 80000000", Lo); end
        checks++; if (Hi !== 32'h00000000) begin failures++; $display("FAIL div_ovf_hi got %h want 0", Hi); end
    endtask

    task automatic test_div_zero;
        int cyc;
        run_op(F_DIV, 32'h12345678, 32'd0, cyc);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL divz_busy_cycles got %0d want 33", cyc); end
        checks++; if (Lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL divz_lo got %h want ffffffff", Lo); end
        checks++; if (Hi !== 32'h12345678) begin failures++; $display("FAIL divz_hi got %h want 12345678", Hi); end
    endtask

    task automatic test_stall_mf;
        int cyc;
        int stall_bad;
        int hold_bad;
        @(negedge CLK);
        Valid = 1'b1; Ins = r_ins(F_DIVU); Rdata1 = 32'd100; Rdata2 = 32'd7;
        @(negedge CLK);
        Ins = r_ins(F_MFLO); Rdata1 = 32'hCAFEF00D; Rdata2 = 32'd3;
        cyc = 0; stall_bad = 0; hold_bad = 0;
        while (Busy && cyc < 200) begin
            if (Stall !== 1'b1) stall_bad++;
            if (Lo !== 32'hFFFFFFFF || Hi !== 32'h12345678) hold_bad++;
            cyc++;
            @(negedge CLK);
        end
        checks++; if (cyc !== 33) begin failures++; $display("FAIL stall_busy_cycles got %0d want 33", cyc); end
        checks++; if (stall_bad !== 0) begin failures++; $display("FAIL stall_while_busy low_cycles=%0d want 0", stall_bad); end
        checks++; if (hold_bad !== 0) begin failures++; $display("FAIL hilo_hold_while_busy changed_cycles=%0d want 0", hold_bad); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL stall_after_busy got %0b want 0", Stall); end
        checks++; if (MfData !== 32'd14) begin failures++; $display("FAIL mflo_data got %0d want 14", MfData); end
        Ins = r_ins(F_MFHI);
        #1;
        checks++; if (MfData !== 32'd2) begin failures++; $display("FAIL mfhi_data got %0d want 2", MfData); end
        @(negedge CLK);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mf_no_busy got %0b want 0", Busy); end
        Valid = 1'b0;
    endtask

    task automatic test_move_to;
        @(negedge CLK);
        Valid = 1'b1; Ins = r_ins(F_MTHI); Rdata1 = 32'h0000ABCD;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL mthi_stall got %0b want 0", Stall); end
        @(negedge CLK);
        checks++; if (Hi !== 32'h0000ABCD) begin failures++; $display("FAIL mthi_hi got %h want 0000abcd", Hi); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got %0b want 0", Busy); end
        checks++; if (Lo !== 32'd14) begin failures++; $display("FAIL mthi_lo_kept got %h want 0000000e", Lo); end
        Ins = r_ins(F_MTLO); Rdata1 = 32'h00001234;
        @(negedge CLK);
        Valid = 1'b0;
        checks++; if (Lo !== 32'h00001234) begin failures++; $display("FAIL mtlo_lo got %h want 00001234", Lo); end
        checks++; if (Hi !== 32'h0000ABCD) begin failures++; $display("FAIL mtlo_hi_kept got %h want 0000abcd", Hi); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        @(negedge CLK);
        Valid = 1'b1; Ins = r_ins(F_MULTU); Rdata1 = 32'hFFFFFFFF; Rdata2 = 32'hFFFFFFFF;
        @(negedge CLK);
        Valid = 1'b0;
        repeat (9) @(negedge CLK);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL midop_busy got %0b want 1", Busy); end
        #2;
        RST = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got %0b want 0", Busy); end
        checks++; if (Hi !== 32'd0) begin failures++; $display("FAIL async_reset_hi got %h want 0", Hi); end
        checks++; if (Lo !== 32'd0) begin failures++; $display("FAIL async_reset_lo got %h want 0", Lo); end
        @(negedge CLK);
        RST = 1'b1;
        run_op(F_MULTU, 32'd3, 32'd4, cyc);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL post_reset_cycles got %0d want 33", cyc); end
        checks++; if (Lo !== 32'd12) begin failures++; $display("FAIL post_reset_lo got %0d want 12", Lo); end
        checks++; if (Hi !== 32'd0) begin failures++; $display("FAIL post_reset_hi got %0d want 0", Hi); end
    endtask

    initial begin
        test_reset();
        test_ignored();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_stall_mf();
        test_move_to();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "simulation did not finish");
    end

endmodule
